// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch front end.
//
// Contents:
//   db_state_t    - debounce FSM state encoding (ZERO, WAIT1, ONE, WAIT0)
//   DB_TICKS_DEF  - production debounce length (20 ms at 100 MHz)
//   CNT_W_DEF     - production debounce counter width
//   DB_TICKS_SIM  - short debounce length used by simulation benches
//   db_level()    - debounced level carried by a given FSM state
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,  // stable low
    WAIT1 = 2'b01,  // saw a high, qualifying it
    ONE   = 2'b10,  // stable high
    WAIT0 = 2'b11   // saw a low, qualifying it
  } db_state_t;

  localparam int DB_TICKS_DEF = 2_000_000;
  localparam int CNT_W_DEF    = 21;
  localparam int DB_TICKS_SIM = 4;

  // The accepted level only changes once a WAIT state completes, so a
  // WAITx state still reports the level it is trying to leave.
  function automatic logic db_level(input db_state_t s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/debounce_fsm.sv
// Synchroniser plus debounce state machine for one raw board input.
//
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   din_raw   - asynchronous, bouncy raw input
//   db        - debounced level
//   rise      - one-cycle registered pulse when db goes 0 -> 1
//   fall      - one-cycle registered pulse when db goes 1 -> 0
//   dbg_state - current debounce state, for observation only
//
// Parameters:
//   DB_TICKS  - stable synchronised samples needed beyond the first one
//               before a new level is accepted (must be >= 2)
//   CNT_W     - counter width, 2**CNT_W must exceed DB_TICKS
//   RST_LEVEL - level assumed at reset (sync flops and FSM start there)
//
// A new level must be seen on DB_TICKS+1 consecutive synchronised samples:
// the first sample moves to WAITx and loads DB_TICKS-1, the remaining
// samples count the value down to zero and the last one accepts it. Any
// sample back at the old level returns to the stable state without a pulse.
module debounce_fsm
  import stopwatch_pkg::*;
#(
  parameter int   DB_TICKS  = DB_TICKS_DEF,
  parameter int   CNT_W     = CNT_W_DEF,
  parameter logic RST_LEVEL = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      din_raw,
  output logic      db,
  output logic      rise,
  output logic      fall,
  output db_state_t dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [1:0]       sync_q;
  logic             s;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  // Second synchroniser flop is the only point the FSM looks at.
  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {2{RST_LEVEL}};
      state  <= RST_LEVEL ? ONE : ZERO;
      cnt    <= CNT_ZERO;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din_raw};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ZERO: begin
        if (s) begin
          state_nxt = WAIT1;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_nxt = ZERO;
        end else if (cnt == CNT_ZERO) begin
          state_nxt = ONE;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_DEC;
        end
      end
      ONE: begin
        if (!s) begin
          state_nxt = WAIT0;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (s) begin
          state_nxt = ONE;
        end else if (cnt == CNT_ZERO) begin
          state_nxt = ZERO;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_DEC;
        end
      end
      default: begin
        state_nxt = ZERO;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  assign db        = db_level(state);
  assign dbg_state = state;

endmodule

// File: rtl/stopwatch_input_ctrl.sv
// Push-button / switch front end for the stopwatch counter.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   btn_go     - raw start/stop push-button
//   btn_clr    - raw clear push-button
//   sw_up      - raw direction switch (1 = count up)
//   go         - registered run level; toggles on each start/stop press
//   clr        - registered one-cycle clear pulse; also stops the watch
//   up         - registered direction; only follows the switch while stopped
//   up_pending - registered flag, high while the switch disagrees with up
//
// Handshake: none. All outputs are plain registered levels/pulses that the
// counter samples every cycle; there is no valid/ready flow control.
module stopwatch_input_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_TICKS = DB_TICKS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_go,
  input  logic btn_clr,
  input  logic sw_up,
  output logic go,
  output logic clr,
  output logic up,
  output logic up_pending
);

  logic      db_go, rise_go, fall_go;
  logic      db_clr, rise_clr, fall_clr;
  logic      db_up, rise_up, fall_up;
  db_state_t st_go, st_clr, st_up;
  logic      go_nxt;

  debounce_fsm #(
    .DB_TICKS (DB_TICKS),
    .CNT_W    (CNT_W),
    .RST_LEVEL(1'b0)
  ) u_db_go (
    .clk      (clk),
    .reset    (reset),
    .din_raw  (btn_go),
    .db       (db_go),
    .rise     (rise_go),
    .fall     (fall_go),
    .dbg_state(st_go)
  );

  debounce_fsm #(
    .DB_TICKS (DB_TICKS),
    .CNT_W    (CNT_W),
    .RST_LEVEL(1'b0)
  ) u_db_clr (
    .clk      (clk),
    .reset    (reset),
    .din_raw  (btn_clr),
    .db       (db_clr),
    .rise     (rise_clr),
    .fall     (fall_clr),
    .dbg_state(st_clr)
  );

  // The direction switch idles high, so its chain starts at 1 to avoid a
  // spurious down-then-up sequence straight after reset.
  debounce_fsm #(
    .DB_TICKS (DB_TICKS),
    .CNT_W    (CNT_W),
    .RST_LEVEL(1'b1)
  ) u_db_up (
    .clk      (clk),
    .reset    (reset),
    .din_raw  (sw_up),
    .db       (db_up),
    .rise     (rise_up),
    .fall     (fall_up),
    .dbg_state(st_up)
  );

  // Only the press edges of go/clr and the level of the switch matter here;
  // the remaining debounce outputs are kept visible on the hierarchy for
  // probing but deliberately go nowhere.
  logic unused_db;
  assign unused_db = ^{db_go, fall_go, db_clr, fall_clr, rise_up, fall_up,
                       st_go, st_clr, st_up};

  // Clear has priority: a simultaneous start/stop press is swallowed so a
  // clear always leaves the watch stopped.
  always_comb begin
    go_nxt = go;
    if (rise_clr) begin
      go_nxt = 1'b0;
    end else if (rise_go) begin
      go_nxt = ~go;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      go         <= 1'b0;
      clr        <= 1'b0;
      up         <= 1'b1;
      up_pending <= 1'b0;
    end else begin
      go  <= go_nxt;
      clr <= rise_clr;
      // Keyed on the next run level so a held-off direction change lands on
      // the very edge the watch stops.
      if (!go_nxt) begin
        up <= db_up;
      end
      // Compared against the current up, so it drops one edge after up
      // catches up with the switch.
      up_pending <= (db_up != up);
    end
  end

endmodule

// File: doc/stopwatch_input_ctrl.md
Name: stopwatch_input_ctrl

Overview:
- Front-end control stage for the stopwatch counter; sits directly upstream of it.
- Converts raw board push-buttons and the count-direction switch into clean control signals: `go` (run level), `clr` (one-cycle clear pulse) and `up` (direction level).
- Each input gets a 2-flop synchroniser, then a debounce FSM. `go` toggles on each start/stop press. Direction changes are applied only while the watch is stopped.

Parameters:
- DB_TICKS, 2_000_000, consecutive stable cycles needed to accept a level change (20 ms at 100 MHz); must be ≥ 2.
- CNT_W, 21, debounce counter width; must satisfy 2^CNT_W > DB_TICKS.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_go  input  1  raw start/stop push-button, asynchronous, bouncy
- btn_clr  input  1  raw clear push-button, asynchronous, bouncy
- sw_up  input  1  raw direction switch, asynchronous, bouncy (1 = count up)
- go  output  1  registered run level to the counter
- clr  output  1  registered one-cycle clear pulse to the counter
- up  output  1  registered direction level to the counter
- up_pending  output  1  high while debounced sw_up differs from `up` (drives an LED)

Behaviour:
- Reset: one clock, reset is synchronous and active-high; clock port `clk`, reset port `reset`.
  - Reset values: go=0, clr=0, up=1, up_pending=0.
  - Sync flops reset to 0, except the sw_up sync chain, which resets to 1.
  - Debounce FSMs reset to ZERO (ONE for sw_up), counter=0.
  - Reset asserted mid-operation aborts any debounce in progress; no pulse is emitted on the reset cycle.
- Synchroniser: 2 flops per input. The FSM sees the raw level 2 edges after it is sampled.
- Debounce FSM (one per input), states ZERO, WAIT1, ONE, WAIT0:
  - ZERO & s=1 → WAIT1, counter loaded with DB_TICKS-1.
  - WAIT1 & s=1: counter≠0 → decrement; counter=0 → ONE, assert internal `rise` for 1 cycle.
  - WAIT1 & s=0 → ZERO (bounce rejected, no pulse).
  - ONE/WAIT0 are symmetric, producing `fall`.
  - Debounced level db = 1 in ONE and WAIT0, 0 otherwise.
- Latency (DB_TICKS=4): raw btn rising, held stable, first sampled at edge 0.
  - `rise` is high in the cycle after edge DB_TICKS+2.
  - go/clr registered outputs change at edge DB_TICKS+3.
- go: toggles on rise_go. Holding the button causes exactly one toggle. Release (fall) has no effect.
- clr:
  - clr=1 for exactly one cycle on rise_clr.
  - The same edge forces go=0, so clearing always stops the watch.
  - Held button produces no further pulses.
- Simultaneous rise_go and rise_clr in the same cycle: clr=1, go=0. Clear wins; no toggle.
- up:
  - On any edge where go=0, up ← db_up.
  - While go=1, up holds its value, and up_pending = (db_up ≠ up).
  - The pending change is applied on the first edge where go=0, including the edge where go falls.
  - up_pending is registered and clears one edge after up updates.
- Counter wrap: cannot occur. It only loads DB_TICKS-1 and decrements to 0.

Decomposition:
- Shared package stopwatch_pkg: db_state_t enum {ZERO, WAIT1, ONE, WAIT0}; constant DB_TICKS_SIM = 4 for benches.
- One sub-module: debounce_fsm.
  - Parameters DB_TICKS, CNT_W, RST_LEVEL.
  - Ports clk, reset, din_raw, db, rise, fall; includes its own synchroniser.
  - Instantiated three times.
- The top level holds only the go/clr/up register logic.

Test Plan:
All cases run with DB_TICKS=4.
- Clean press: btn_go 0→1 held 20 cycles → go 0→1 at edge 7 after first high sample; stays 1; release changes nothing; second press → go=0.
- Bounce: btn_go toggles 1,0,1,0 every 2 cycles then holds 1 → exactly one toggle, 7 edges after the final stable 1; no toggle during bouncing.
- Clear while running: go=1, press btn_clr → clr=1 for exactly 1 cycle; go=0 on the same edge; holding btn_clr 50 cycles gives no second pulse.
- Simultaneous: btn_go and btn_clr rise on the same cycle while go=0 → clr pulse, go stays 0.
- Direction hold-off: go=1, up=1, sw_up→0 stable → up_pending=1, up stays 1; press btn_go (stop) → up=0 on the go-fall edge, up_pending=0 one edge later.
- Reset mid-debounce: btn_go high for 3 cycles after sync, then reset for 1 cycle while still held → go=0, FSM restarts; toggle occurs 7 edges after reset deasserts.
